// File: rtl/coeff_token_decoder_pkg.sv
// Shared types and code tables for the CAVLC coeff_token decoder.
//   tbl_sel_e : which VLC table a token is decoded against
//   token_t   : decoded token (TotalCoeff, TrailingOnes, NumShift, Error)
//   *_LEN/*_BITS : codeword length / value, indexed TotalCoeff*4 + TrailingOnes,
//                  value right-aligned in LEN bits, LEN 0 marks an unused slot.
package coeff_token_decoder_pkg;

  typedef enum logic [2:0] {T0, T1, T2, FLC, CDC, BAD} tbl_sel_e;

  typedef struct packed {
    logic [4:0] total_coeff;
    logic [1:0] trailing_ones;
    logic [4:0] num_shift;
    logic       error;
  } token_t;

  localparam logic [5:0] FLC_ZERO_CODE = 6'b000011;
  localparam int         NUM_ENTRIES   = 68;
  localparam int         CDC_ENTRIES   = 20;

  // 0 <= nC < 2
  localparam logic [4:0] T0_LEN [NUM_ENTRIES] = '{
    1, 0, 0, 0,   6, 2, 0, 0,   8, 6, 3, 0,   9, 8, 7, 5,  10, 9, 8, 6,
   11,10, 9, 7,  13,11,10, 8,  13,13,11, 9,  13,13,13,10,  14,14,13,11,
   14,14,14,13,  15,15,14,14,  15,15,15,14,  16,15,15,15,  16,16,16,15,
   16,16,16,16,  16,16,16,16};
  localparam logic [3:0] T0_BITS [NUM_ENTRIES] = '{
    1, 0, 0, 0,   5, 1, 0, 0,   7, 4, 1, 0,   7, 6, 5, 3,   7, 6, 5, 3,
    7, 6, 5, 4,  15, 6, 5, 4,  11,14, 5, 4,   8,10,13, 4,  15,14, 9, 4,
   11,10,13,12,  15,14, 9,12,  11,10,13, 8,  15, 1, 9,12,  11,14,13, 8,
    7,10, 9,12,   4, 6, 5, 8};

  // 2 <= nC < 4
  localparam logic [4:0] T1_LEN [NUM_ENTRIES] = '{
    2, 0, 0, 0,   6, 2, 0, 0,   6, 5, 3, 0,   7, 6, 6, 4,   8, 6, 6, 4,
    8, 7, 7, 5,   9, 8, 8, 6,  11, 9, 9, 6,  11,11,11, 7,  12,11,11, 9,
   12,12,12,11,  12,12,12,11,  13,13,13,12,  13,13,13,13,  13,14,13,13,
   14,14,14,13,  14,14,14,14};
  localparam logic [3:0] T1_BITS [NUM_ENTRIES] = '{
    3, 0, 0, 0,  11, 2, 0, 0,   7, 7, 3, 0,   7,10, 9, 5,   7, 6, 5, 4,
    4, 6, 5, 6,   7, 6, 5, 8,  15, 6, 5, 4,  11,14,13, 4,  15,10, 9, 4,
   11,14,13,12,   8,10, 9, 8,  15,14,13,12,  11,10, 9,12,   7,11, 6, 8,
    9, 8,10, 1,   7, 6, 5, 4};

  // 4 <= nC < 8
  localparam logic [4:0] T2_LEN [NUM_ENTRIES] = '{
    4, 0, 0, 0,   6, 4, 0, 0,   6, 5, 4, 0,   6, 5, 5, 4,   7, 5, 5, 4,
    7, 5, 5, 4,   7, 6, 6, 4,   7, 6, 6, 4,   8, 7, 7, 5,   8, 8, 7, 6,
    9, 8, 8, 7,   9, 9, 8, 8,   9, 9, 9, 8,  10, 9, 9, 9,  10,10,10,10,
   10,10,10,10,  10,10,10,10};
  localparam logic [3:0] T2_BITS [NUM_ENTRIES] = '{
   15, 0, 0, 0,  15,14, 0, 0,  11,15,13, 0,   8,12,14,12,  15,10,11,11,
   11, 8, 9,10,   9,14,13, 9,   8,10, 9, 8,  15,14,13,13,  11,14,10,12,
   15,10,13,12,  11,14, 9,12,   8,10,13, 8,  13, 7, 9,12,   9,12,11,10,
    5, 8, 7, 6,   1, 4, 3, 2};

  // nC == -1 (chroma DC); includes the all-zero 7-bit codeword for 4/3
  localparam logic [4:0] CDC_LEN [CDC_ENTRIES] = '{
    2, 0, 0, 0,   6, 1, 0, 0,   6, 6, 3, 0,   6, 7, 7, 6,   6, 8, 8, 7};
  localparam logic [3:0] CDC_BITS [CDC_ENTRIES] = '{
    1, 0, 0, 0,   7, 1, 0, 0,   4, 6, 1, 0,   3, 3, 2, 5,   2, 3, 2, 0};

  // Leading-zero count of a 16-bit word; 16 when the word is zero.
  function automatic logic [4:0] clz16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd16;
    for (int b = 0; b < 16; b++) begin
      if (v[b]) n = 5'(15 - b);
    end
    return n;
  endfunction

endpackage

// File: rtl/coeff_token_decoder_table.sv
// Combinational coeff_token lookup (second pipeline stage).
//   sel_i    : table select
//   lz_i     : leading-zero count of the bit window (0..16)
//   suffix_i : window bits following the leading one, MSB-aligned
//   tok_o    : decoded token; Error set when nothing in the table matches
module coeff_token_table
  import coeff_token_decoder_pkg::*;
(
  input  tbl_sel_e    sel_i,
  input  logic [4:0]  lz_i,
  input  logic [14:0] suffix_i,
  output token_t      tok_o
);

  // A table entry matches when its own leading-zero count equals the
  // window's and the suffix bits it actually uses agree. Bits past the
  // codeword length are masked off, so they are don't-care.
  function automatic logic entry_match(input logic [4:0] lz, input logic [14:0] sfx,
                                       input logic [4:0] len, input logic [3:0] code);
    logic [15:0] aligned;
    logic [4:0]  e_lz;
    logic [4:0]  n_sfx;
    logic [14:0] e_sfx;
    logic [14:0] mask;
    aligned = {12'b0, code} << (5'd16 - len);
    e_lz    = clz16(aligned);
    if (e_lz >= len) begin
      // all-zero codeword: any window with at least len leading zeros
      return lz >= len;
    end
    e_sfx = aligned[14:0] << e_lz;
    n_sfx = len - e_lz - 5'd1;
    mask  = ~(15'h7FFF >> n_sfx);
    return (lz == e_lz) && (((sfx ^ e_sfx) & mask) == 15'd0);
  endfunction

  logic [15:0] window_top;
  logic [5:0]  flc_field;
  logic [4:0]  ent_len;
  logic [3:0]  ent_bits;
  logic        found;

  always_comb begin
    tok_o      = '0;
    found      = 1'b0;
    ent_len    = '0;
    ent_bits   = '0;
    // Rebuild the window from leading one + suffix to recover Bits[15:10].
    window_top = {1'b1, suffix_i};
    flc_field  = 6'(window_top >> (lz_i + 5'd10));
    case (sel_i)
      FLC: begin
        tok_o.num_shift = 5'd6;
        if (flc_field != FLC_ZERO_CODE) begin
          tok_o.total_coeff   = {1'b0, flc_field[5:2]} + 5'd1;
          tok_o.trailing_ones = flc_field[1:0];
        end
      end
      T0, T1, T2, CDC: begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          ent_len  = '0;
          ent_bits = '0;
          case (sel_i)
            T0: begin ent_len = T0_LEN[i]; ent_bits = T0_BITS[i]; end
            T1: begin ent_len = T1_LEN[i]; ent_bits = T1_BITS[i]; end
            T2: begin ent_len = T2_LEN[i]; ent_bits = T2_BITS[i]; end
            CDC: begin
              if (i < CDC_ENTRIES) begin
                ent_len  = CDC_LEN[i % CDC_ENTRIES];
                ent_bits = CDC_BITS[i % CDC_ENTRIES];
              end
            end
            default: ;
          endcase
          if (!found && ent_len != 5'd0 && entry_match(lz_i, suffix_i, ent_len, ent_bits)) begin
            found               = 1'b1;
            tok_o.total_coeff   = 5'(i / 4);
            tok_o.trailing_ones = 2'(i % 4);
            tok_o.num_shift     = ent_len;
          end
        end
        if (!found) tok_o.error = 1'b1;
      end
      default: tok_o.error = 1'b1;
    endcase
  end

endmodule

// File: rtl/coeff_token_decoder.sv
// Two-stage pipelined H.264 CAVLC coeff_token decoder with valid/ready flow.
//   Clk, Rst             : clock, synchronous active-high reset
//   InValid/InReady      : input handshake for Bits (16-bit window) and Nc
//   OutValid/OutReady    : output handshake for the decoded token
//   TotalCoeff, TrailingOnes, NumShift, Error : decoded token fields
//   TokenCount           : saturating count of delivered tokens
module coeff_token_decoder
  import coeff_token_decoder_pkg::*;
#(
  parameter int CHROMA_DC_EN = 1,
  parameter int COUNT_W      = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               InValid,
  output logic               InReady,
  input  logic [15:0]        Bits,
  input  logic [5:0]         Nc,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [4:0]         TotalCoeff,
  output logic [1:0]         TrailingOnes,
  output logic [4:0]         NumShift,
  output logic               Error,
  output logic [COUNT_W-1:0] TokenCount
);

  tbl_sel_e           sel_d, s1_sel_q;
  logic [4:0]         lz_d, s1_lz_q;
  logic [14:0]        suffix_d, s1_suffix_q;
  logic               s1_valid_q, s1_valid_d;
  logic               s2_valid_q, s2_valid_d;
  token_t             tok_d, s2_tok_q;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               s2_free, s1_move, in_fire, out_fire;

  // Stage 1 front end: table select, leading-zero count, aligned suffix.
  always_comb begin
    sel_d = BAD;
    if (Nc <= 6'd1)       sel_d = T0;
    else if (Nc <= 6'd3)  sel_d = T1;
    else if (Nc <= 6'd7)  sel_d = T2;
    else if (Nc <= 6'd16) sel_d = FLC;
    else if (Nc == 6'h3F) sel_d = (CHROMA_DC_EN != 0) ? CDC : BAD;
  end

  assign lz_d     = clz16(Bits);
  // The leading one shifts out of the 15-bit result, leaving the bits after it.
  assign suffix_d = Bits[14:0] << lz_d;

  // Handshake: S2 can take a token if empty or its token leaves this cycle.
  assign s2_free    = ~s2_valid_q | OutReady;
  assign s1_move    = s1_valid_q & s2_free;
  assign InReady    = ~s1_valid_q | s2_free;
  assign in_fire    = InValid & InReady;
  assign out_fire   = s2_valid_q & OutReady;
  assign s1_valid_d = in_fire | (s1_valid_q & ~s2_free);
  assign s2_valid_d = s1_move | (s2_valid_q & ~OutReady);
  assign count_d    = (out_fire && count_q != '1) ? count_q + 1'b1 : count_q;

  coeff_token_table u_table (
    .sel_i    (s1_sel_q),
    .lz_i     (s1_lz_q),
    .suffix_i (s1_suffix_q),
    .tok_o    (tok_d)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_valid_q  <= 1'b0;
      s1_sel_q    <= BAD;
      s1_lz_q     <= '0;
      s1_suffix_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_tok_q    <= '0;
      count_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      count_q    <= count_d;
      if (in_fire) begin
        s1_sel_q    <= sel_d;
        s1_lz_q     <= lz_d;
        s1_suffix_q <= suffix_d;
      end
      if (s1_move) s2_tok_q <= tok_d;
    end
  end

  assign OutValid     = s2_valid_q;
  assign TotalCoeff   = s2_tok_q.total_coeff;
  assign TrailingOnes = s2_tok_q.trailing_ones;
  assign NumShift     = s2_tok_q.num_shift;
  assign Error        = s2_tok_q.error;
  assign TokenCount   = count_q;

endmodule

// File: tb/tb_coeff_token_decoder.sv
module tb_coeff_token_decoder;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst, InValid, OutReady;
  logic [15:0] Bits;
  logic [5:0]  Nc;

  logic        in_ready_a, out_valid_a, err_a;
  logic [4:0]  tc_a, ns_a;
  logic [1:0]  t1_a;
  logic [15:0] cnt_a;
  logic        in_ready_b, out_valid_b, err_b;
  logic [4:0]  tc_b, ns_b;
  logic [1:0]  t1_b;
  logic [2:0]  cnt_b;

  coeff_token_decoder #(.CHROMA_DC_EN(1), .COUNT_W(16)) dut_a (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(in_ready_a),
    .Bits(Bits), .Nc(Nc), .OutValid(out_valid_a), .OutReady(OutReady),
    .TotalCoeff(tc_a), .TrailingOnes(t1_a), .NumShift(ns_a), .Error(err_a),
    .TokenCount(cnt_a));

  // Same stimulus, chroma DC disabled and a 3-bit counter to reach saturation.
  coeff_token_decoder #(.CHROMA_DC_EN(0), .COUNT_W(3)) dut_b (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(in_ready_b),
    .Bits(Bits), .Nc(Nc), .OutValid(out_valid_b), .OutReady(OutReady),
    .TotalCoeff(tc_b), .TrailingOnes(t1_b), .NumShift(ns_b), .Error(err_b),
    .TokenCount(cnt_b));

  logic [12:0] tok_a, tok_b;
  assign tok_a = {tc_a, t1_a, ns_a, err_a};
  assign tok_b = {tc_b, t1_b, ns_b, err_b};

  typedef struct packed {
    logic [12:0] a;
    logic [12:0] b;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_cnt = 0;
  int          seen_out = 0;
  bit          hold_valid = 0;
  bit          saw_block = 0;
  logic [12:0] hold_tok;

  localparam logic [12:0] ERR = 13'h0001;

  function automatic logic [12:0] tk(input int tc, input int t1, input int ns);
    return {5'(tc), 2'(t1), 5'(ns), 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor / scoreboard: pops one expectation per delivered token.
  always @(negedge Clk) begin : monitor
    exp_t e;
    if (Rst) begin
      hold_valid = 0;
    end else begin
      if (InValid && !in_ready_a) saw_block = 1;
      if (out_valid_a) begin
        seen_out++;
        if (hold_valid) check("held_stable", 32'(tok_a), 32'(hold_tok));
        if (OutReady) begin
          if (exp_q.size() == 0) begin
            check("unexpected_token", 32'(tok_a), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            $display("[TB] token %0d: TotalCoeff=%0d TrailingOnes=%0d NumShift=%0d Error=%0d count=%0d",
                     exp_cnt, tc_a, t1_a, ns_a, err_a, cnt_a);
            check("token_a", 32'(tok_a), 32'(e.a));
            check("token_b", 32'(tok_b), 32'(e.b));
            check("valid_b", 32'(out_valid_b), 32'd1);
            check("count_a", 32'(cnt_a), 32'(exp_cnt));
            check("count_b", 32'(cnt_b), (exp_cnt > 7) ? 32'd7 : 32'(exp_cnt));
            exp_cnt++;
          end
        end
        hold_valid = !OutReady;
        hold_tok   = tok_a;
      end else begin
        hold_valid = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] b, input logic [5:0] n,
                      input logic [12:0] ea, input logic [12:0] eb);
    exp_t e;
    int   k;
    e.a = ea;
    e.b = eb;
    Bits = b;
    Nc = n;
    InValid = 1'b1;
    exp_q.push_back(e);
    for (k = 0; k < 50; k++) begin
      @(negedge Clk);
      if (in_ready_a) break;
    end
    if (k == 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge Clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    InValid = 1'b0;
    @(posedge Clk);
    #1;
    exp_q.delete();
    exp_cnt = 0;
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_outputs", 32'(tok_a), 32'd0);
    check("rst_count_a", 32'(cnt_a), 32'd0);
    check("rst_count_b", 32'(cnt_b), 32'd0);
    Rst = 1'b0;
    check("in_ready_after_rst", 32'(in_ready_a), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1;
    InValid = 1'b0;
    Bits = '0;
    Nc = '0;
    OutReady = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    do_reset();

    // Latency: accepted at one edge, valid after the following edge.
    send(16'h8000, 6'd0, tk(0,0,1), tk(0,0,1));
    check("latency_n1", 32'(out_valid_a), 32'd0);
    @(posedge Clk);
    #1;
    check("latency_n2", 32'(out_valid_a), 32'd1);

    // Directed vectors: Bits, Nc, expected (CHROMA_DC_EN=1), expected (=0).
    send(16'h2000, 6'd0,  tk(2,2,3),   tk(2,2,3));
    send(16'h2FFF, 6'd1,  tk(2,2,3),   tk(2,2,3));
    send(16'h0C00, 6'd8,  tk(0,0,6),   tk(0,0,6));
    send(16'h0000, 6'd8,  tk(1,0,6),   tk(1,0,6));
    send(16'hC000, 6'd2,  tk(0,0,2),   tk(0,0,2));
    send(16'h4000, 6'h3F, tk(0,0,2),   ERR);
    send(16'h0000, 6'd0,  ERR,         ERR);
    send(16'h1400, 6'd0,  tk(1,0,6),   tk(1,0,6));
    send(16'h0004, 6'd1,  tk(16,0,16), tk(16,0,16));
    send(16'h8000, 6'd4,  tk(7,3,4),   tk(7,3,4));
    send(16'hF000, 6'd7,  tk(0,0,4),   tk(0,0,4));
    send(16'h0080, 6'd5,  tk(16,3,10), tk(16,3,10));
    send(16'hFFFF, 6'd16, tk(16,3,6),  tk(16,3,6));
    send(16'h8000, 6'd17, ERR,         ERR);
    send(16'h8000, 6'h3E, ERR,         ERR);
    send(16'h001C, 6'd3,  tk(16,0,14), tk(16,0,14));
    send(16'h8000, 6'd3,  tk(1,1,2),   tk(1,1,2));
    send(16'h4000, 6'd2,  tk(4,3,4),   tk(4,3,4));
    send(16'h0000, 6'h3F, tk(4,3,7),   ERR);
    send(16'h0300, 6'h3F, tk(4,1,8),   ERR);
    send(16'h8000, 6'h3F, tk(1,1,1),   ERR);
    drain();

    // Back-to-back stream of 8 FLC tokens with a 3-cycle output stall.
    saw_block = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send({4'(i), 2'(i % 4), 10'h155}, 6'd8, tk(i + 1, i % 4, 6), tk(i + 1, i % 4, 6));
      end
      begin
        repeat (3) @(posedge Clk);
        #1;
        OutReady = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        OutReady = 1'b1;
      end
    join
    drain();
    check("in_ready_dropped", 32'(saw_block), 32'd1);

    // Reset with both stages full: nothing from before may reappear.
    OutReady = 1'b0;
    send(16'h8000, 6'd0, tk(0,0,1), tk(0,0,1));
    send(16'h2000, 6'd0, tk(2,2,3), tk(2,2,3));
    check("full_before_rst", 32'(out_valid_a), 32'd1);
    check("in_ready_full", 32'(in_ready_a), 32'd0);
    do_reset();
    OutReady = 1'b1;
    seen_out = 0;
    repeat (6) @(posedge Clk);
    #1;
    check("no_stale_token", 32'(seen_out), 32'd0);

    send(16'hC000, 6'd3, tk(0,0,2), tk(0,0,2));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
